// File: rtl/external_spike_router.sv
// -----------------------------------------------------------------------------
// external_spike_router
//
// Merges external stimulus spikes with recurrent neuron-column spikes onto the
// synapse-row spike lines. Each column spike carries a polarity (on/off); a
// per-(row, column) connection bit for each polarity decides whether that
// spike reaches the row. All contributions to one row in a cycle collapse into
// a single registered pulse, one clock after the inputs are sampled.
//
// Ports
//   clk           system (fast) clock, rising edge active
//   reset_n       asynchronous active-low reset; clears both outputs at once
//   ext_valid     [NUM_SYNAPSE_ROWS]  external stimulus spike per row
//   col_valid     [NUM_COLS]          neuron output spike per column
//   col_on_off    [NUM_COLS]          spike polarity per column, 1 = on
//   conn_on       [ROWS*COLS]         bit r*NUM_COLS+c: on-spikes of c feed r
//   conn_off      [ROWS*COLS]         bit r*NUM_COLS+c: off-spikes of c feed r
//   row_valid     [NUM_SYNAPSE_ROWS]  routed spike per row (registered)
//   row_external  [NUM_SYNAPSE_ROWS]  external stimulus contributed (registered)
// -----------------------------------------------------------------------------
module external_spike_router #(
    parameter int NUM_SYNAPSE_ROWS = 257,
    parameter int NUM_COLS         = 48
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_SYNAPSE_ROWS-1:0]          ext_valid,
    input  logic [NUM_COLS-1:0]                  col_valid,
    input  logic [NUM_COLS-1:0]                  col_on_off,
    input  logic [NUM_SYNAPSE_ROWS*NUM_COLS-1:0] conn_on,
    input  logic [NUM_SYNAPSE_ROWS*NUM_COLS-1:0] conn_off,
    output logic [NUM_SYNAPSE_ROWS-1:0]          row_valid,
    output logic [NUM_SYNAPSE_ROWS-1:0]          row_external
);

    // Split each column spike into its polarity lane once, shared by all rows.
    // A column that is not valid drives neither lane, so its polarity and
    // connection bits cannot matter.
    logic [NUM_COLS-1:0]         on_spike;
    logic [NUM_COLS-1:0]         off_spike;
    logic [NUM_SYNAPSE_ROWS-1:0] recurrent_hit;

    assign on_spike  = col_valid &  col_on_off;
    assign off_spike = col_valid & ~col_on_off;

    // Connection bits are configuration used directly in the arrival cycle;
    // they are deliberately not registered. Setting both polarity bits for a
    // (row, column) pair makes that row fire on either polarity.
    for (genvar r = 0; r < NUM_SYNAPSE_ROWS; r++) begin : g_row
        assign recurrent_hit[r] =
            |((conn_on [r*NUM_COLS +: NUM_COLS] & on_spike) |
              (conn_off[r*NUM_COLS +: NUM_COLS] & off_spike));
    end

    // Single output register stage: any number of simultaneous contributors
    // to a row yields one pulse, and consecutive input cycles give
    // consecutive output cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_valid    <= '0;
            row_external <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            row_valid    <= ext_valid | recurrent_hit;
            row_external <= ext_valid;
        end
    end

endmodule

// File: tb/tb_external_spike_router.sv
// -----------------------------------------------------------------------------
// tb_external_spike_router
//
// Directed scenarios (reset, pass-through, polarity, fan-in, fan-out,
// streaming) followed by randomized traffic with periodic reconfiguration.
// Expected outputs come from a per-(row, column) loop model of the routing
// rules, evaluated on the inputs presented before each rising edge.
// -----------------------------------------------------------------------------
module tb_external_spike_router;

    localparam int ROWS = 257;
    localparam int COLS = 48;

    logic                 clk;
    logic                 reset_n;
    logic [ROWS-1:0]      ext_valid;
    logic [COLS-1:0]      col_valid;
    logic [COLS-1:0]      col_on_off;
    logic [ROWS*COLS-1:0] conn_on;
    logic [ROWS*COLS-1:0] conn_off;
    logic [ROWS-1:0]      row_valid;
    logic [ROWS-1:0]      row_external;

    int n_vec  = 0;
    int n_fail = 0;

    external_spike_router #(
        .NUM_SYNAPSE_ROWS(ROWS),
        .NUM_COLS        (COLS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ext_valid   (ext_valid),
        .col_valid   (col_valid),
        .col_on_off  (col_on_off),
        .conn_on     (conn_on),
        .conn_off    (conn_off),
        .row_valid   (row_valid),
        .row_external(row_external)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [ROWS-1:0] got,
                         input logic [ROWS-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: a row fires if its external input is set or any valid column
    // has a matching connection for the polarity it is currently emitting.
    function automatic void model(output logic [ROWS-1:0] exp_v,
                                  output logic [ROWS-1:0] exp_e);
        for (int r = 0; r < ROWS; r++) begin
            bit hit;
            hit = ext_valid[r];
            for (int c = 0; c < COLS; c++) begin
                if (col_valid[c]) begin
                    if (col_on_off[c] && conn_on[r*COLS+c])   hit = 1'b1;
                    if (!col_on_off[c] && conn_off[r*COLS+c]) hit = 1'b1;
                end
            end
            exp_v[r] = hit;
            exp_e[r] = ext_valid[r];
        end
    endfunction

    // Inputs are driven 1 time unit after a rising edge; the model is taken
    // before the next edge and outputs are sampled 1 unit after it.
    task automatic step(input string tag);
        logic [ROWS-1:0] exp_v, exp_e;
        model(exp_v, exp_e);
        @(posedge clk);
        #1;
        check({tag, "/valid"}, row_valid, exp_v);
        check({tag, "/ext"}, row_external, exp_e);
    endtask

    task automatic clear_inputs();
        ext_valid  = '0;
        col_valid  = '0;
        col_on_off = '0;
    endtask

    task automatic randomize_conn(input int density);
        for (int i = 0; i < ROWS*COLS; i++) begin
            conn_on[i]  = ($urandom_range(0, density) == 0);
            conn_off[i] = ($urandom_range(0, density) == 0);
        end
    endtask

    initial begin
        logic [ROWS-1:0] one_hot;
        logic [ROWS-1:0] ones;
        ones = '1;

        reset_n = 1'b0;
        clear_inputs();
        conn_on  = '0;
        conn_off = '0;
        #1;
        check("por/valid", row_valid, '0);
        check("por/ext", row_external, '0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        #1;

        // Reset behaviour: fill the outputs, then assert reset mid-cycle.
        ext_valid = '1;
        col_valid = '1;
        step("fill");
        #2 reset_n = 1'b0;
        #1;
        check("rst_async/valid", row_valid, '0);
        check("rst_async/ext", row_external, '0);
        @(posedge clk);
        #1;
        check("rst_held/valid", row_valid, '0);
        check("rst_held/ext", row_external, '0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release/valid", row_valid, ones);
        check("rst_release/ext", row_external, ones);
        clear_inputs();
        step("idle0");

        // External pass-through on row 5, exactly one pulse.
        ext_valid[5] = 1'b1;
        one_hot = '0;
        one_hot[5] = 1'b1;
        @(posedge clk);
        #1;
        check("pass5/valid", row_valid, one_hot);
        check("pass5/ext", row_external, one_hot);
        ext_valid = '0;
        step("pass5_end");

        // Polarity routing from column 0.
        conn_on[10*COLS+0]  = 1'b1;
        conn_off[11*COLS+0] = 1'b1;
        col_valid[0]  = 1'b1;
        col_on_off[0] = 1'b1;
        one_hot = '0;
        one_hot[10] = 1'b1;
        @(posedge clk);
        #1;
        check("pol_on/valid", row_valid, one_hot);
        check("pol_on/ext", row_external, '0);
        col_on_off[0] = 1'b0;
        one_hot = '0;
        one_hot[11] = 1'b1;
        @(posedge clk);
        #1;
        check("pol_off/valid", row_valid, one_hot);
        // Invalid column with connections present has no effect.
        col_valid[0]  = 1'b0;
        col_on_off[0] = 1'b1;
        step("col_invalid");
        conn_on  = '0;
        conn_off = '0;
        clear_inputs();

        // Fan-in merge on row 3.
        conn_on[3*COLS+1]  = 1'b1;
        conn_on[3*COLS+47] = 1'b1;
        col_valid[1]   = 1'b1;  col_on_off[1]  = 1'b1;
        col_valid[47]  = 1'b1;  col_on_off[47] = 1'b1;
        ext_valid[3]   = 1'b1;
        one_hot = '0;
        one_hot[3] = 1'b1;
        @(posedge clk);
        #1;
        check("fanin/valid", row_valid, one_hot);
        check("fanin/ext", row_external, one_hot);
        clear_inputs();
        step("fanin_end");
        conn_on = '0;

        // Fan-out from column 2 to every row.
        for (int r = 0; r < ROWS; r++) conn_on[r*COLS+2] = 1'b1;
        col_valid[2]  = 1'b1;
        col_on_off[2] = 1'b1;
        @(posedge clk);
        #1;
        check("fanout/valid", row_valid, ones);
        check("fanout/ext", row_external, '0);
        clear_inputs();
        step("fanout_end");
        conn_on = '0;

        // Both polarity bits set: fires on either polarity.
        conn_on[20*COLS+7]  = 1'b1;
        conn_off[20*COLS+7] = 1'b1;
        col_valid[7] = 1'b1;
        col_on_off[7] = 1'b0;
        step("both_off");
        col_on_off[7] = 1'b1;
        step("both_on");
        clear_inputs();
        conn_on  = '0;
        conn_off = '0;

        // Streaming: four back-to-back external spikes on row 0.
        ext_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) step("stream");
        ext_valid[0] = 1'b0;
        step("stream_end");

        // Randomized traffic with periodic reconfiguration.
        for (int cfg = 0; cfg < 6; cfg++) begin
            randomize_conn(cfg < 3 ? 63 : 7);
            for (int i = 0; i < 80; i++) begin
                for (int r = 0; r < ROWS; r++)
                    ext_valid[r] = ($urandom_range(0, 15) == 0);
                col_valid  = COLS'({$urandom, $urandom});
                col_on_off = COLS'({$urandom, $urandom});
                if ($urandom_range(0, 3) == 0) col_valid = '0;
                // Occasional single-bit reconfiguration between spikes.
                if ($urandom_range(0, 9) == 0)
                    conn_on[$urandom_range(0, ROWS*COLS-1)] ^= 1'b1;
                step("rand");
            end
        end

        clear_inputs();
        step("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
